paralelo_serial_tx: RTL

Transmit-side serializer of the PHY. Accepts 8-bit bytes from the link layer through a valid/ready handshake and shifts them out MSB first, one bit per `clk_32f` cycle. It sits directly upstream of the receive-side serial-to-parallel stage and guarantees the alignment pattern that stage needs. After reset, and on request, it sends at least `N_SYNC` comma bytes (0xBC). In every byte slot with no data it sends 0xBC as idle fill.

---
 rtl/phy_pkg.sv | 7 +
 rtl/paralelo_serial_tx_if.sv | 13 +
 rtl/tx_shifter.sv | 34 +++
 rtl/paralelo_serial_tx.sv | 68 ++++++
 4 files changed

// File: rtl/phy_pkg.sv
// Constants shared by the PHY transmit serializer and the receive-side deserializer.
// The comma byte doubles as alignment pattern and idle fill.
package phy_pkg;
  localparam int BYTE_W = 8;
  localparam logic [BYTE_W-1:0] COMMA = 8'hBC;
  typedef enum logic {SYNC = 1'b0, ACTIVE = 1'b1} tx_state_t;
endpackage

// File: rtl/paralelo_serial_tx_if.sv
// Link-layer byte handshake into the serializer.
// valid/ready: a byte moves on a rising edge where valid_in & ready_out; ready_out never depends on valid_in.
interface paralelo_serial_tx_if;
  import phy_pkg::*;

  logic [BYTE_W-1:0] data_in;
  logic              valid_in;
  logic              resync_in;
  logic              ready_out;

  modport master (output data_in, output valid_in, output resync_in, input ready_out);
  modport slave  (input data_in, input valid_in, input resync_in, output ready_out);
endinterface

// File: rtl/tx_shifter.sv
// Bit-slot counter, shift register and registered serial output.
// load_pulse marks the cycle whose rising edge loads the next byte, MSB first.
module tx_shifter
  import phy_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic [BYTE_W-1:0] nb,
  output logic              load_pulse,
  output logic              data_out
);
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] shreg;

  assign load_pulse = (bit_cnt == 3'd7);

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      bit_cnt  <= 3'd7;
      shreg    <= '0;
      data_out <= 1'b0;
    end else begin
      bit_cnt <= bit_cnt + 3'd1;
      // The MSB goes straight to data_out; shreg keeps only the remaining bits.
      if (load_pulse) begin
        data_out <= nb[BYTE_W-1];
        shreg    <= {nb[BYTE_W-2:0], 1'b0};
      end else begin
        data_out <= shreg[BYTE_W-1];
        shreg    <= {shreg[BYTE_W-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/paralelo_serial_tx.sv
// PHY transmit serializer: SYNC/ACTIVE framing FSM and byte handshake around tx_shifter.
// SYNC sends N_SYNC commas before data is accepted; empty ACTIVE slots carry comma fill.
module paralelo_serial_tx
  import phy_pkg::*;
#(
  parameter int unsigned N_SYNC = 4
)(
  input  logic                  clk_32f,
  input  logic                  reset_L,
  paralelo_serial_tx_if.slave   link,
  output logic                  data_out,
  output logic                  active_out,
  output logic                  valid_tx_out,
  output logic                  state_dbg
);
  localparam logic       S_SYNC    = SYNC;
  localparam logic       S_ACTIVE  = ACTIVE;
  localparam logic [3:0] SYNC_LAST = 4'(N_SYNC);

  logic              state;
  logic [3:0]        sync_cnt;
  logic [3:0]        sync_nxt;
  logic              load_pulse;
  logic              transfer;
  logic [BYTE_W-1:0] nb;

  assign link.ready_out = (state == S_ACTIVE) & load_pulse & ~link.resync_in;
  assign transfer       = link.valid_in & link.ready_out;
  assign nb             = transfer ? link.data_in : COMMA;
  assign sync_nxt       = sync_cnt + 4'd1;
  assign active_out     = (state == S_ACTIVE);
  assign state_dbg      = state;

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state        <= S_SYNC;
      sync_cnt     <= 4'd0;
      valid_tx_out <= 1'b0;
    end else if (load_pulse) begin
      valid_tx_out <= transfer;
      case (state)
        S_SYNC: begin
          if (sync_nxt == SYNC_LAST) begin
            sync_cnt <= 4'd0;
            state    <= S_ACTIVE;
          end else begin
            sync_cnt <= sync_nxt;
          end
        end
        default: begin
          // The comma loaded at the resync edge is the first of the N_SYNC.
          if (link.resync_in) begin
            sync_cnt <= 4'd1;
            state    <= S_SYNC;
          end
        end
      endcase
    end
  end

  tx_shifter u_shifter (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .nb         (nb),
    .load_pulse (load_pulse),
    .data_out   (data_out)
  );
endmodule
